// File: rtl/aes_block_packer_if.sv
// Byte-stream and aes_main handshake bundle for aes_block_packer.
// master = stream source / aes_main side, slave = packer side.
interface aes_block_packer_if;
  logic [7:0]   s_byte;
  logic         s_valid;
  logic         s_last;
  logic         s_ready;
  logic         aes_ready;
  logic [127:0] aes_data;
  logic         aes_stb;

  modport master (
    output s_byte, s_valid, s_last, aes_ready,
    input  s_ready, aes_data, aes_stb
  );

  modport slave (
    input  s_byte, s_valid, s_last, aes_ready,
    output s_ready, aes_data, aes_stb
  );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream into 128-bit blocks, queues them and strobes them into aes_main.
// Optional PKCS#7 padding (and the extra full pad block) is enabled by defining AES_PACK_PKCS7_EN.
module aes_block_packer #(
  parameter int DEPTH        = 4,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  aes_block_packer_if.slave        bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     timeout_err,
  output logic [31:0]              blocks_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TIMEOUT);
  localparam logic [127:0]  PAD_BLOCK = {16{8'h10}};

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STB  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [3:0]   idx_r;
  logic [127:0] buf_r;
  logic         run_r;
  logic [127:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r, level_r;
  logic [1:0]   state_r;
  logic [HW-1:0] hold_cnt_r;
  logic [127:0] aes_data_r;
  logic         aes_stb_r;
  logic         timeout_err_r;
  logic [31:0]  blocks_sent_r;

  logic         full_s, empty_s, ready_s, accept_s;
  logic         push_one_s, push2_s, pop_s;
  logic [PW-1:0] push_cnt_s, wr_nxt_s, rd_nxt_s;
  logic [AW-1:0] wr_addr_s, wr_addr2_s;
  logic [7:0]   pad_s;
  logic [127:0] blk_s;

  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign wr_addr_s  = wr_ptr_r[AW-1:0];
  assign wr_addr2_s = wr_ptr_r[AW-1:0] + AW'(1);

`ifdef AES_PACK_PKCS7_EN
  assign pad_s   = 8'h0F - {4'h0, idx_r};
  assign push2_s = accept_s && bus.s_last && (idx_r == 4'd15);
  // A last byte that completes a block also needs room for the trailing pad block
  assign ready_s = (bus.s_last && (idx_r == 4'd15))
                   ? (level_r <= PW'(DEPTH - 2))
                   : (!full_s || ((idx_r != 4'd15) && !bus.s_last));
`else
  assign pad_s   = 8'h00;
  assign push2_s = 1'b0;
  assign ready_s = !full_s || ((idx_r != 4'd15) && !bus.s_last);
`endif

  assign bus.s_ready = run_r && ready_s;
  assign accept_s    = bus.s_valid && bus.s_ready;
  assign push_one_s  = accept_s && ((idx_r == 4'd15) || bus.s_last);
  assign pop_s       = (state_r == ST_STB);
  assign wr_nxt_s    = wr_ptr_r + push_cnt_s;
  assign rd_nxt_s    = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};

  // Merge stored bytes, the incoming byte and padding into the candidate block
  always_comb begin
    blk_s = '0;
    for (int k = 0; k < 16; k++) begin
      if (4'(k) < idx_r) begin
        blk_s[127-8*k -: 8] = buf_r[127-8*k -: 8];
      end else if (4'(k) == idx_r) begin
        blk_s[127-8*k -: 8] = bus.s_byte;
      end else begin
        blk_s[127-8*k -: 8] = pad_s;
      end
    end
  end

  // Number of FIFO entries written this cycle
  always_comb begin
    push_cnt_s = '0;
    if (push2_s) begin
      push_cnt_s = PW'(2);
    end else if (push_one_s) begin
      push_cnt_s = PW'(1);
    end else begin
      push_cnt_s = '0;
    end
  end

  // Byte index and partial-block accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r <= 4'd0;
      buf_r <= 128'd0;
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
      if (accept_s) begin
        buf_r <= blk_s;
        idx_r <= push_one_s ? 4'd0 : idx_r + 4'd1;
      end
    end
  end

  // Block FIFO storage and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 128'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_one_s) begin
        mem_r[wr_addr_s] <= blk_s;
      end
      if (push2_s) begin
        mem_r[wr_addr2_s] <= PAD_BLOCK;
      end
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      level_r  <= wr_nxt_s - rd_nxt_s;
    end
  end

  // Issue FSM: strobe one block, then wait for aes_main to drop ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      hold_cnt_r    <= '0;
      aes_data_r    <= 128'd0;
      aes_stb_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      blocks_sent_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!empty_s && bus.aes_ready) begin
            aes_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            aes_stb_r  <= 1'b1;
            state_r    <= ST_STB;
          end
        end
        ST_STB: begin
          aes_stb_r     <= 1'b0;
          blocks_sent_r <= blocks_sent_r + 32'd1;
          hold_cnt_r    <= '0;
          state_r       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (!bus.aes_ready) begin
            state_r <= ST_IDLE;
          end else if (hold_cnt_r == HOLD_MAX) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end
        end
        default: begin
          aes_stb_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.aes_data = aes_data_r;
  assign bus.aes_stb  = aes_stb_r;
  assign fifo_level   = level_r;
  assign timeout_err  = timeout_err_r;
  assign blocks_sent  = blocks_sent_r;

endmodule
